// File: rtl/simon_pkg.sv
// Shared types and constants for the tone scheduler: FSM states, default
// inter-tone gap and the note frequencies the game plays.
package simon_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_TONE = 2'd1,
        ST_GAP  = 2'd2
    } tone_state_e;

    localparam int GAP_MS_DEFAULT = 50;
    localparam int FREQ_W         = 10;
    localparam int DUR_W          = 10;

    localparam logic [FREQ_W-1:0] NOTE_G3 = 10'd196;
    localparam logic [FREQ_W-1:0] NOTE_C4 = 10'd262;
    localparam logic [FREQ_W-1:0] NOTE_E4 = 10'd330;
    localparam logic [FREQ_W-1:0] NOTE_G4 = 10'd392;
    localparam logic [FREQ_W-1:0] NOTE_G5 = 10'd784;

endpackage

// File: rtl/ms_timebase.sv
// Millisecond strobe generator; restart realigns the tick counter so every
// scheduler state starts on a fresh millisecond boundary.
module ms_timebase (
    input  logic        clk,
    input  logic        rst,
    input  logic [15:0] ticks_per_milli,
    input  logic        restart,
    output logic        strobe
);

    logic [15:0] tick_cnt;
    logic [15:0] tick_max;

    // A zero tick rate behaves like one tick per millisecond.
    assign tick_max = (ticks_per_milli == 16'd0) ? 16'd0 : ticks_per_milli - 16'd1;
    // >= keeps the counter bounded if the rate shrinks mid-count.
    assign strobe   = (tick_cnt >= tick_max);

    always_ff @(posedge clk) begin
        if (rst || restart) begin
            tick_cnt <= 16'd0;
        end else if (strobe) begin
            tick_cnt <= 16'd0;
        end else begin
            tick_cnt <= tick_cnt + 16'd1;
        end
    end

endmodule

// File: rtl/tone_sched.sv
// Round-robin tone scheduler: grants the tone generator to one requester for
// its duration, then inserts a silent gap before serving the next.
module tone_sched
    import simon_pkg::*;
#(
    parameter int NUM_REQ = 4,
    parameter int GAP_MS  = GAP_MS_DEFAULT
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic [15:0]             ticks_per_milli,
    input  logic [NUM_REQ-1:0]      req,
    input  logic [10*NUM_REQ-1:0]   freq,
    input  logic [10*NUM_REQ-1:0]   dur_ms,
    input  logic                    stop,
    output logic [NUM_REQ-1:0]      grant,
    output logic [NUM_REQ-1:0]      done,
    output logic [FREQ_W-1:0]      sound_freq,
    output logic                    busy,
    output logic [1:0]              dbg_state
);

    // Handshake: req[i] is a level request held for the whole tone; grant is
    // the registered one-hot owner. Dropping req while granted aborts the tone
    // (no done); done pulses one cycle on normal completion.

    localparam int IDX_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
    localparam logic [15:0] GAP_LIM = 16'(GAP_MS);
    localparam tone_state_e AFTER_TONE = (GAP_MS == 0) ? ST_IDLE : ST_GAP;

    tone_state_e        state;
    logic [IDX_W-1:0]   last_idx;
    logic [IDX_W-1:0]   owner;
    logic [DUR_W-1:0]   cap_dur;
    logic [15:0]        ms_cnt;

    logic               strobe;
    logic               restart;
    logic [IDX_W-1:0]   pick_idx;
    logic [FREQ_W-1:0]  win_freq;
    logic [DUR_W-1:0]   win_dur;
    logic               any_req;
    logic               owner_drop;
    logic               ms_hit;
    logic               gap_hit;

    function automatic logic [IDX_W-1:0] rr_pick(input logic [NUM_REQ-1:0] r,
                                                 input logic [IDX_W-1:0]   last);
        int   c;
        logic found;
        rr_pick = last;
        found   = 1'b0;
        for (int k = 1; k <= NUM_REQ; k++) begin
            c = (int'(last) + k) % NUM_REQ;
            if (!found && r[c]) begin
                rr_pick = IDX_W'(c);
                found   = 1'b1;
            end
        end
    endfunction

    assign any_req    = |req;
    assign pick_idx   = rr_pick(req, last_idx);
    assign win_freq   = freq[int'(pick_idx)*10 +: 10];
    assign win_dur    = dur_ms[int'(pick_idx)*10 +: 10];
    assign owner_drop = !req[owner];
    assign ms_hit     = strobe && ((ms_cnt + 16'd1) >= {6'd0, cap_dur});
    assign gap_hit    = strobe && ((ms_cnt + 16'd1) >= GAP_LIM);
    assign busy       = (state != ST_IDLE);
    assign dbg_state  = state;

    // Restart the timebase on exactly the cycles where the state changes.
    always_comb begin
        restart = 1'b0;
        case (state)
            ST_IDLE: restart = !stop && any_req;
            ST_TONE: restart = stop || (cap_dur == '0) || owner_drop || ms_hit;
            ST_GAP:  restart = stop || gap_hit;
            default: restart = 1'b1;
        endcase
    end

    ms_timebase u_timebase (
        .clk             (clk),
        .rst             (rst),
        .ticks_per_milli (ticks_per_milli),
        .restart         (restart),
        .strobe          (strobe)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= ST_IDLE;
            grant      <= '0;
            done       <= '0;
            sound_freq <= '0;
            last_idx   <= IDX_W'(NUM_REQ - 1);
            owner      <= '0;
            cap_dur    <= '0;
            ms_cnt     <= 16'd0;
        end else begin
            done <= '0;

            if (restart) begin
                ms_cnt <= 16'd0;
            end else if (strobe && state != ST_IDLE) begin
                ms_cnt <= ms_cnt + 16'd1;
            end

            case (state)
                ST_IDLE: begin
                    if (!stop && any_req) begin
                        state    <= ST_TONE;
                        grant    <= NUM_REQ'(1) << pick_idx;
                        owner    <= pick_idx;
                        last_idx <= pick_idx;
                        cap_dur  <= win_dur;
                        // Zero-length tones complete on their only granted cycle.
                        if (win_dur == '0) begin
                            sound_freq <= '0;
                            done       <= NUM_REQ'(1) << pick_idx;
                        end else begin
                            sound_freq <= win_freq;
                        end
                    end
                end
                ST_TONE: begin
                    if (stop || cap_dur == '0) begin
                        state      <= ST_IDLE;
                        grant      <= '0;
                        sound_freq <= '0;
                    end else if (owner_drop) begin
                        state      <= AFTER_TONE;
                        grant      <= '0;
                        sound_freq <= '0;
                    end else if (ms_hit) begin
                        state      <= AFTER_TONE;
                        done       <= grant;
                        grant      <= '0;
                        sound_freq <= '0;
                    end
                end
                ST_GAP: begin
                    if (stop || gap_hit) begin
                        state <= ST_IDLE;
                    end
                end
                default: begin
                    state      <= ST_IDLE;
                    grant      <= '0;
                    sound_freq <= '0;
                end
            endcase
        end
    end

endmodule

// File: doc/tone_sched.md
TONE_SCHED -- requirements
Module: tone_sched

Interface
REQ-001 SHALL have parameter NUM_REQ, default 4, number of tone requesters.
REQ-002 SHALL have parameter GAP_MS, default 50, silent milliseconds inserted after each tone.
REQ-003 SHALL have port clk, input, 1, single clock.
REQ-004 SHALL have port rst, input, 1, reset, synchronous active-high.
REQ-005 SHALL have port ticks_per_milli, input, 16, clk cycles per millisecond.
REQ-006 SHALL have port req, input, NUM_REQ, per-requester tone request level.
REQ-007 SHALL have port freq, input, 10*NUM_REQ, packed per-requester frequency in Hz; slot i is bits [10i+9:10i].
REQ-008 SHALL have port dur_ms, input, 10*NUM_REQ, packed per-requester duration in ms.
REQ-009 SHALL have port stop, input, 1, immediate cancel of the current activity.
REQ-010 SHALL have port grant, output, NUM_REQ, one-hot owner of the tone generator.
REQ-011 SHALL have port done, output, NUM_REQ, 1-cycle completion pulse per requester.
REQ-012 SHALL have port sound_freq, output, 10, frequency driven to the tone generator; 0 means silence.
REQ-013 SHALL have port busy, output, 1, high whenever the state is not IDLE.

Function
REQ-014 SHALL implement states IDLE, TONE and GAP.
REQ-015 Millisecond strobe SHALL pulse when the tick counter equals max(ticks_per_milli,1)-1; the tick counter SHALL restart at 0 on every state entry.
REQ-016 In IDLE with any req high and stop low, the scheduler SHALL pick the requester by round-robin, starting from the index after the last granted one.
REQ-017 On the pick cycle, the scheduler SHALL capture freq and dur_ms of the winner; on the next cycle grant is one-hot, sound_freq equals the captured freq, and the state is TONE (1-cycle latency).
REQ-018 In TONE, when the ms count reaches captured dur on a strobe, the scheduler SHALL pulse done[i] for 1 cycle, zero sound_freq and grant, and enter GAP (or IDLE if GAP_MS=0).
REQ-019 A winner with dur_ms=0 SHALL be granted for exactly 1 cycle with sound_freq 0, pulse done on that cycle, and return to IDLE with no gap.
REQ-020 A captured freq of 0 SHALL be treated as a valid timed rest, with full duration, done pulse and gap.
REQ-021 If req[i] of the owner drops during TONE, the scheduler SHALL abort next cycle: sound_freq 0, grant 0, no done, enter GAP.
REQ-022 GAP SHALL hold sound_freq 0 and grant 0 for GAP_MS ms, then enter IDLE; requests seen during GAP SHALL wait.
REQ-023 stop high in any state SHALL force IDLE on the next cycle with sound_freq 0, grant 0 and no done; stop has priority over completion on the same cycle.
REQ-024 Changes to freq/dur_ms after capture SHALL be ignored until the next grant.
REQ-025 The round-robin pointer SHALL update only on grant; an abort or stop SHALL NOT give the aborted requester priority.
REQ-026 done and grant SHALL never both indicate different requesters in the same cycle, and at most one done bit SHALL be high.

Reset
REQ-027 rst SHALL set the state to IDLE, grant=0, done=0, sound_freq=0, busy=0, tick and ms counters to 0, and the pointer so that requester 0 wins first.
REQ-028 rst mid-TONE SHALL silence the output on the next cycle with no done pulse.

Structure
REQ-029 A shared package (simon_pkg) SHALL hold the state enum, note frequency constants (G3=196, C4=262, E4=330, G5=784, etc.) and the GAP_MS default.
REQ-030 The millisecond timebase SHALL be a sub-module ms_timebase (inputs clk, rst, ticks_per_milli, restart; output strobe).
REQ-031 sound_freq SHALL connect directly to the freq input of the existing tone generator.

Verification (ticks_per_milli=2, GAP_MS=50)
REQ-032 req[0] held with freq 196 and dur 3 -> 1 cycle later grant=0001 and sound_freq=196 for 6 cycles, done[0] pulses, then 100 cycles of silence, then busy=0.
REQ-033 req[0] and req[2] held together -> grants alternate 0001, 0100, 0001, each separated by a gap.
REQ-034 req[1] dropped 2 cycles into a 10 ms tone -> next cycle sound_freq=0, no done[1], GAP entered.
REQ-035 stop pulsed mid-tone, including on the completion cycle -> IDLE next cycle, no done, busy=0.
REQ-036 req[3] with dur 0 -> grant=1000 for 1 cycle, done[3] on that cycle, sound_freq stays 0, no gap.
REQ-037 rst asserted mid-TONE -> all outputs 0 next cycle; then req[1] and req[0] together -> requester 0 wins first.
